decode_issue_stage: RTL
=======================

# decode_issue_stage

Decode/operand-read stage of the pipelined CPU: accepts one fetched instruction per cycle, drives the register-file read addresses, and detects RAW hazards against in-flight writes with a per-register pending-write scoreboard. It stalls fetch while a source is pending and registers the decoded instruction and operands into the ID/EX pipeline register. It sits between the fetch stage and the execute stage, alongside the register file.

## Interface
Parameters:
- BIT_WIDTH, 32, data/instruction width
- REG_WIDTH, 4, register index width (16 registers)
- CNT_WIDTH, 2, pending-write counter width per register (max 3 in flight)

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents an instruction
- in_instr  in  BIT_WIDTH  instruction word
- in_pc  in  BIT_WIDTH  PC+4 of the instruction
- in_ready  out  1  stage accepts in_instr this cycle (not stalled)
- flush  in  1  EX redirect; kill the instruction currently held in ID
- rf_sr1, rf_sr2  out  REG_WIDTH  register-file read addresses (combinational from in_instr)
- rf_sr1_data, rf_sr2_data  in  BIT_WIDTH  register-file read data (write-bypassed)
- wb_en  in  1  writeback commits this cycle (same signal as register-file write enable)
- wb_dr  in  REG_WIDTH  writeback destination
- out_valid  out  1  ID/EX holds a valid instruction
- out_class  out  3  decoded instruction class
- out_alu_fn  out  4  instr[27:24]
- out_rd  out  REG_WIDTH  destination
- out_wr  out  1  instruction writes out_rd
- out_a, out_b  out  BIT_WIDTH  source operands
- out_imm  out  BIT_WIDTH  sign-extended instr[15:0]
- out_pc  out  BIT_WIDTH  passed-through in_pc

## Operation
- Fields: class=instr[30:28], fn=instr[27:24], rd=[23:20], rs1=[19:16], rs2=[15:12], imm=[15:0]; instr[31] reserved, ignored.
- Classes: 0 ALU-R (rs1,rs2→rd), 1 ALU-I (rs1→rd), 2 LOAD (rs1→rd), 3 STORE (rs1,rs2), 4 BRANCH (rs1,rs2), 5 JAL (rs1→rd), 6/7 NOP (no reads, no write, issues as out_valid=1 bubble-op with out_wr=0).
- Scoreboard: cnt[r], CNT_WIDTH bits. Issue with write: cnt[rd]+1. wb_en: cnt[wb_dr]-1. Both on same register same cycle: unchanged.
- Source r is ready if cnt[r]==0, or cnt[r]==1 and wb_en and wb_dr==r (register file bypasses the write).
- stall = in_valid & (any used source not ready | issue would overflow cnt[rd] at 3).
- in_ready = !stall. Issue = in_valid & !stall & !flush.
- On issue: ID/EX loads decode fields, out_a=rf_sr1_data, out_b=rf_sr2_data (ALU-I/LOAD/JAL: out_b=out_imm), out_valid=1.
- Stall or !in_valid: ID/EX loads bubble (out_valid=0, out_wr=0); other fields don't-care but held.
- flush: no issue this cycle, no scoreboard increment, in_ready=1 (fetch drops the killed word). Issued instructions are never squashed.
- Register 0 is ordinary (no hardwired zero).
- wb_en with cnt[wb_dr]==0: protocol error; count saturates at 0.

## Timing
- Reset (async): all cnt=0, out_valid=0, out_wr=0, all other out_* = 0.
- Latency: instruction accepted in cycle N appears on out_* in N+1.
- Scoreboard update is visible to the instruction in ID in the next cycle; back-to-back dependent pair stalls until writeback of producer.
- in_ready and rf_sr* are combinational from current inputs and state; no combinational path from out_*.
- Release from reset mid-stream: first edge after reset_n rises may issue.

## Structure
- Shared package: class encodings, field bit positions, CNT_WIDTH default.
- Sub-module reg_scoreboard: cnt array, inc/dec ports, per-source ready outputs, overflow flag.

## Test plan
- Reset with in_valid=1 → out_valid=0, all cnt=0 while reset_n=0; first issue one cycle after release.
- ALU-R r3←r1,r2 then ALU-R r4←r3,r3 → second stalls (in_ready=0, bubbles) until wb_en,wb_dr=3; issues that same cycle with bypassed data.
- Three writes to r5 in flight, fourth write to r5 → stalls on overflow until one wb_en,wb_dr=5.
- wb_en,wb_dr=7 same cycle as issue writing r7 with cnt[7]=1 → cnt[7] stays 1.
- flush with in_valid=1, ALU-I r2 → out_valid=0 next cycle, cnt[2] unchanged, in_ready=1.
- ALU-I rs1=1, imm=0xFFFE → out_b=0xFFFFFFFE, out_imm=0xFFFFFFFE, out_wr=1.

Source files
------------

// File: rtl/decode_issue_stage_pkg.sv
// Shared decode definitions for the decode/issue stage: instruction classes,
// field bit positions and the default scoreboard counter width.
package decode_issue_stage_pkg;

    localparam int DEF_CNT_WIDTH = 2;

    localparam int CLS_HI = 30;
    localparam int CLS_LO = 28;
    localparam int FN_HI  = 27;
    localparam int FN_LO  = 24;
    localparam int RD_HI  = 23;
    localparam int RD_LO  = 20;
    localparam int RS1_HI = 19;
    localparam int RS1_LO = 16;
    localparam int RS2_HI = 15;
    localparam int RS2_LO = 12;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef enum logic [2:0] {
        CLS_ALU_R  = 3'd0,
        CLS_ALU_I  = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_JAL    = 3'd5,
        CLS_NOP6   = 3'd6,
        CLS_NOP7   = 3'd7
    } instr_class_e;

endpackage

// File: rtl/decode_issue_stage_reg_scoreboard.sv
// Per-register pending-write counters with source-ready and overflow lookup.
// A writeback to a register with one pending write is treated as ready (bypassed).
module reg_scoreboard #(
    parameter int REG_WIDTH = 4,
    parameter int CNT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_inc,
    input  logic [REG_WIDTH-1:0] i_inc_rd,
    input  logic                 i_dec,
    input  logic [REG_WIDTH-1:0] i_dec_rd,
    input  logic [REG_WIDTH-1:0] i_sr1,
    input  logic [REG_WIDTH-1:0] i_sr2,
    output logic                 o_sr1_ready,
    output logic                 o_sr2_ready,
    output logic                 o_rd_full
);

    localparam int NREG = 1 << REG_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_cnt [NREG];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                // Inc and dec on the same register cancel; dec saturates at zero.
                if (i_inc && i_inc_rd == REG_WIDTH'(i) && !(i_dec && i_dec_rd == REG_WIDTH'(i)))
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                else if (i_dec && i_dec_rd == REG_WIDTH'(i) && !(i_inc && i_inc_rd == REG_WIDTH'(i))
                         && r_cnt[i] != '0)
                    r_cnt[i] <= r_cnt[i] - CNT_ONE;
            end
        end
    end

    always_comb begin
        o_sr1_ready = (r_cnt[i_sr1] == '0) ||
                      (r_cnt[i_sr1] == CNT_ONE && i_dec && i_dec_rd == i_sr1);
        o_sr2_ready = (r_cnt[i_sr2] == '0) ||
                      (r_cnt[i_sr2] == CNT_ONE && i_dec && i_dec_rd == i_sr2);
        o_rd_full   = (r_cnt[i_inc_rd] == CNT_MAX) && !(i_dec && i_dec_rd == i_inc_rd);
    end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/operand-read stage: decodes the fetched word, stalls on RAW hazards or
// pending-count overflow, and registers the decoded instruction into ID/EX.
module decode_issue_stage
    import decode_issue_stage_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int REG_WIDTH = 4,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [BIT_WIDTH-1:0] in_instr,
    input  logic [BIT_WIDTH-1:0] in_pc,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [REG_WIDTH-1:0] rf_sr1,
    output logic [REG_WIDTH-1:0] rf_sr2,
    input  logic [BIT_WIDTH-1:0] rf_sr1_data,
    input  logic [BIT_WIDTH-1:0] rf_sr2_data,
    input  logic                 wb_en,
    input  logic [REG_WIDTH-1:0] wb_dr,
    output logic                 out_valid,
    output logic [2:0]           out_class,
    output logic [3:0]           out_alu_fn,
    output logic [REG_WIDTH-1:0] out_rd,
    output logic                 out_wr,
    output logic [BIT_WIDTH-1:0] out_a,
    output logic [BIT_WIDTH-1:0] out_b,
    output logic [BIT_WIDTH-1:0] out_imm,
    output logic [BIT_WIDTH-1:0] out_pc
);

    instr_class_e         w_class;
    logic [REG_WIDTH-1:0] w_rd;
    logic [BIT_WIDTH-1:0] w_imm;
    logic                 w_use1, w_use2, w_wr, w_b_imm;
    logic                 w_sr1_ready, w_sr2_ready, w_rd_full;
    logic                 w_stall, w_issue;
    logic                 w_unused_rsvd;

    logic                 r_valid, r_wr;
    logic [2:0]           r_class;
    logic [3:0]           r_fn;
    logic [REG_WIDTH-1:0] r_rd;
    logic [BIT_WIDTH-1:0] r_a, r_b, r_imm, r_pc;

    assign w_class       = instr_class_e'(in_instr[CLS_HI:CLS_LO]);
    assign w_rd          = in_instr[RD_HI:RD_LO];
    assign rf_sr1        = in_instr[RS1_HI:RS1_LO];
    assign rf_sr2        = in_instr[RS2_HI:RS2_LO];
    assign w_imm         = {{(BIT_WIDTH-16){in_instr[IMM_HI]}}, in_instr[IMM_HI:IMM_LO]};
    assign w_unused_rsvd = |in_instr[BIT_WIDTH-1:31];

    always_comb begin
        w_use1  = 1'b0;
        w_use2  = 1'b0;
        w_wr    = 1'b0;
        w_b_imm = 1'b0;
        case (w_class)
            CLS_ALU_R: begin
                w_use1 = 1'b1;
                w_use2 = 1'b1;
                w_wr   = 1'b1;
            end
            CLS_ALU_I, CLS_LOAD, CLS_JAL: begin
                w_use1  = 1'b1;
                w_wr    = 1'b1;
                w_b_imm = 1'b1;
            end
            CLS_STORE, CLS_BRANCH: begin
                w_use1 = 1'b1;
                w_use2 = 1'b1;
            end
            default: ;
        endcase
    end

    // A flushed word is dropped by fetch, so ready is forced high during flush.
    assign w_stall  = in_valid & ((w_use1 & ~w_sr1_ready) | (w_use2 & ~w_sr2_ready) |
                                  (w_wr & w_rd_full));
    assign in_ready = ~w_stall | flush;
    assign w_issue  = in_valid & ~w_stall & ~flush;

    reg_scoreboard #(
        .REG_WIDTH(REG_WIDTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) u_scoreboard (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_inc       (w_issue & w_wr),
        .i_inc_rd    (w_rd),
        .i_dec       (wb_en),
        .i_dec_rd    (wb_dr),
        .i_sr1       (rf_sr1),
        .i_sr2       (rf_sr2),
        .o_sr1_ready (w_sr1_ready),
        .o_sr2_ready (w_sr2_ready),
        .o_rd_full   (w_rd_full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_wr    <= 1'b0;
            r_class <= '0;
            r_fn    <= '0;
            r_rd    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
        end else if (w_issue) begin
            r_valid <= 1'b1;
            r_wr    <= w_wr;
            r_class <= in_instr[CLS_HI:CLS_LO];
            r_fn    <= in_instr[FN_HI:FN_LO];
            r_rd    <= w_rd;
            r_a     <= rf_sr1_data;
            r_b     <= w_b_imm ? w_imm : rf_sr2_data;
            r_imm   <= w_imm;
            r_pc    <= in_pc;
        end else begin
            r_valid <= 1'b0;
            r_wr    <= 1'b0;
        end
    end

    assign out_valid  = r_valid;
    assign out_wr     = r_wr;
    assign out_class  = r_class;
    assign out_alu_fn = r_fn;
    assign out_rd     = r_rd;
    assign out_a      = r_a;
    assign out_b      = r_b;
    assign out_imm    = r_imm;
    assign out_pc     = r_pc;

endmodule
